code_seq_gen: RTL and testbench

CODE_SEQ_GEN -- requirements
Module: code_seq_gen

---
 rtl/code_pkg.sv | 13 +
 rtl/code_shaper.sv | 27 ++
 rtl/code_seq_gen.sv | 126 ++++++++++++
 tb/tb_code_seq_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/code_pkg.sv
// code_pkg: shared state encoding and default widths for the code sequence generator.
package code_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_CODE_W = 32;
    localparam int DEF_OUT_W  = 16;
    localparam int DEF_CNT_W  = 32;

endpackage

// File: rtl/code_shaper.sv
// code_shaper: registers a signed sample of +amp / -amp for the next digit, or 0 when inactive.
module code_shaper
    import code_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_active,
    input  logic                    i_digit,
    input  logic [OUT_W-2:0]        i_amp,
    output logic signed [OUT_W-1:0] o_signal
);

    // The magnitude is one bit narrower than the sample, so negation never overflows.
    logic signed [OUT_W-1:0] mag;

    assign mag = {1'b0, i_amp};

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            o_signal <= '0;
        else
            o_signal <= i_active ? (i_digit ? mag : -mag) : '0;
    end

endmodule

// File: rtl/code_seq_gen.sv
// code_seq_gen: emits a latched binary code as a burst of +/-amp digits, each held tb cycles.
// Defining CODE_SEQ_GEN_COMPL_EN alternates code A and complementary code B on successive bursts.
module code_seq_gen
    import code_pkg::*;
#(
    parameter int CODE_W = DEF_CODE_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_sinc,
    input  logic [CODE_W-1:0]       i_codigo,
    input  logic [CODE_W-1:0]       i_codigo_b,
    input  logic [CNT_W-1:0]        i_numdig,
    input  logic [CNT_W-1:0]        i_tb,
    input  logic [OUT_W-2:0]        i_amp,
    output logic signed [OUT_W-1:0] o_signal,
    output logic                    o_code,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_sel
);

    localparam int DW = $clog2(CODE_W + 1);

    state_t            state, state_n;
    logic [DW-1:0]     dig, dig_n, nd_r, nd_n;
    logic [CNT_W-1:0]  cnt, cnt_n, tb_r, tb_n;
    logic [CODE_W-1:0] code_r, code_n, code_in, code_cur, code_nxt;
    logic [OUT_W-2:0]  amp_r, amp_n;
    logic              start, cnt_end, dig_end, done_n;

`ifdef CODE_SEQ_GEN_COMPL_EN
    logic use_b;

    assign code_in = use_b ? i_codigo_b : i_codigo;

    // use_b names the code for the next accepted burst; o_sel keeps the one in use.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            use_b <= 1'b0;
            o_sel <= 1'b0;
        end else if (start) begin
            use_b <= ~use_b;
            o_sel <= use_b;
        end
    end
`else
    logic unused_b;

    assign unused_b = ^i_codigo_b;
    assign code_in  = i_codigo;
    assign o_sel    = 1'b0;
`endif

    assign start   = (state == IDLE) && i_sinc && (i_numdig != '0);
    assign cnt_end = cnt == tb_r - CNT_W'(1);
    assign dig_end = dig == nd_r - DW'(1);

    always_comb begin
        state_n = state;
        dig_n   = dig;
        cnt_n   = cnt;
        nd_n    = nd_r;
        tb_n    = tb_r;
        code_n  = code_r;
        amp_n   = amp_r;
        done_n  = 1'b0;
        if (start) begin
            state_n = RUN;
            dig_n   = '0;
            cnt_n   = '0;
            nd_n    = (i_numdig > CNT_W'(CODE_W)) ? DW'(CODE_W) : i_numdig[DW-1:0];
            tb_n    = (i_tb == '0) ? CNT_W'(1) : i_tb;
            code_n  = code_in;
            amp_n   = i_amp;
        end else if (state == RUN) begin
            cnt_n = cnt_end ? '0 : cnt + CNT_W'(1);
            if (cnt_end && dig_end) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end else if (cnt_end) begin
                dig_n = dig + DW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state  <= IDLE;
            dig    <= '0;
            cnt    <= '0;
            nd_r   <= '0;
            tb_r   <= '0;
            code_r <= '0;
            amp_r  <= '0;
            o_done <= 1'b0;
        end else begin
            state  <= state_n;
            dig    <= dig_n;
            cnt    <= cnt_n;
            nd_r   <= nd_n;
            tb_r   <= tb_n;
            code_r <= code_n;
            amp_r  <= amp_n;
            o_done <= done_n;
        end
    end

    // Shifts avoid selecting with an index wider than the code vector needs.
    assign code_cur = code_r >> dig;
    assign code_nxt = code_n >> dig_n;
    assign o_busy   = state == RUN;
    assign o_code   = o_busy & code_cur[0];

    code_shaper #(.OUT_W(OUT_W)) u_shaper (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_active (state_n == RUN),
        .i_digit  (code_nxt[0]),
        .i_amp    (amp_n),
        .o_signal (o_signal)
    );

endmodule

// File: tb/tb_code_seq_gen.sv
// tb_code_seq_gen: directed checks of burst timing, digit mapping, limits, reset and code selection.
module tb_code_seq_gen;

`ifdef CODE_SEQ_GEN_COMPL_EN
    localparam bit COMPL = 1'b1;
`else
    localparam bit COMPL = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, sinc;
    logic [31:0]        codigo, codigo_b, numdig, tbits;
    logic [14:0]        amp;
    logic signed [15:0] sig;
    logic               code, busy, done, sel;
    logic [31:0]        pat;
    int                 checks = 0;
    int                 errors = 0;
    int                 exp1 [12] = '{1000, 1000, 1000, 1000, 1000, 1000,
                                      -1000, -1000, -1000, 1000, 1000, 1000};

    code_seq_gen dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_sinc     (sinc),
        .i_codigo   (codigo),
        .i_codigo_b (codigo_b),
        .i_numdig   (numdig),
        .i_tb       (tbits),
        .i_amp      (amp),
        .o_signal   (sig),
        .o_code     (code),
        .o_busy     (busy),
        .o_done     (done),
        .o_sel      (sel)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; sinc = 1'b0; codigo = '0; codigo_b = '0;
        numdig = '0; tbits = '0; amp = '0;
        tick; tick;
        chk("rst_signal", sig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_code", code, 0);
        chk("rst_sel", sel, 0);
        rst_n = 1'b1;
        tick;

        // Basic burst 1011 x4, tb=3; inputs changed and sinc pulsed mid-burst
        codigo = 32'b1011; numdig = 4; tbits = 3; amp = 1000; codigo_b = '1;
        sinc = 1'b1;
        tick;
        sinc = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            chk($sformatf("b1_sig_c%0d", i), sig, exp1[i-1]);
            chk($sformatf("b1_busy_c%0d", i), busy, 1);
            chk($sformatf("b1_done_c%0d", i), done, 0);
            if (i == 2) begin codigo = '0; amp = 5; end
            sinc = (i == 5);
            tick;
        end
        chk("b1_done", done, 1);
        chk("b1_end_busy", busy, 0);
        chk("b1_end_sig", sig, 0);
        chk("b1_end_code", code, 0);
        chk("b1_sel", sel, 0);
        tick;
        chk("b1_done_pulse", done, 0);

        // Second burst uses the new inputs (code B in the complementary build)
        sinc = 1'b1;
        tick;
        sinc = 1'b0;
        chk("b2_sig", sig, COMPL ? 5 : -5);
        chk("b2_code", code, COMPL ? 1 : 0);
        chk("b2_sel", sel, COMPL ? 1 : 0);
        for (int i = 1; i <= 12; i++) tick;
        chk("b2_done", done, 1);

        // numdig = 0: no burst, no done
        numdig = 0;
        sinc = 1'b1;
        tick;
        sinc = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("z_busy_c%0d", i), busy, 0);
            chk($sformatf("z_done_c%0d", i), done, 0);
            chk($sformatf("z_sig_c%0d", i), sig, 0);
            tick;
        end
        chk("z_sel", sel, COMPL ? 1 : 0);

        // numdig clamped to 32, tb=0 treated as 1
        pat = 32'hA5A5_0F0F;
        codigo = pat; codigo_b = ~pat; numdig = 40; tbits = 0; amp = 7;
        sinc = 1'b1;
        tick;
        sinc = 1'b0;
        chk("c_sel", sel, 0);
        for (int i = 1; i <= 32; i++) begin
            chk($sformatf("c_code_d%0d", i - 1), code, pat[i-1]);
            chk($sformatf("c_sig_d%0d", i - 1), sig, pat[i-1] ? 7 : -7);
            tick;
        end
        chk("c_done", done, 1);
        chk("c_busy", busy, 0);

        // Continuous sinc: back-to-back bursts every 5 cycles
        codigo = 32'b10; codigo_b = 32'b10; numdig = 2; tbits = 2; amp = 3;
        sinc = 1'b1;
        tick;
        for (int i = 1; i <= 15; i++) begin
            int p;
            p = (i - 1) % 5;
            chk($sformatf("bb_sig_c%0d", i), sig, (p == 4) ? 0 : (p < 2) ? -3 : 3);
            chk($sformatf("bb_done_c%0d", i), done, (p == 4) ? 1 : 0);
            chk($sformatf("bb_busy_c%0d", i), busy, (p == 4) ? 0 : 1);
            if (p != 4)
                chk($sformatf("bb_sel_c%0d", i), sel, (COMPL && ((i - 1) / 5) % 2 == 0) ? 1 : 0);
            if (i == 14) sinc = 1'b0;
            tick;
        end
        chk("bb_idle", busy, 0);

        // Reset in the middle of digit 2
        codigo = 32'b0100; codigo_b = '1; numdig = 4; tbits = 2; amp = 9;
        sinc = 1'b1;
        tick;
        sinc = 1'b0;
        for (int i = 1; i <= 4; i++) tick;
        chk("r_sig_d2", sig, 9);
        chk("r_code_d2", code, 1);
        rst_n = 1'b0;
        #1;
        chk("r_sig_async", sig, 0);
        chk("r_busy_async", busy, 0);
        chk("r_code_async", code, 0);
        chk("r_sel_async", sel, 0);
        tick;
        rst_n = 1'b1;
        tick;
        sinc = 1'b1;
        tick;
        sinc = 1'b0;
        chk("r_restart_sig", sig, -9);
        chk("r_restart_busy", busy, 1);
        chk("r_restart_sel", sel, 0);
        tick; tick;
        chk("r_restart_d1", sig, -9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
